// File: rtl/step_motor_pkg.sv
// Shared definitions for the step_motor drive interface and its loop-back decoder.
package step_motor_pkg;

    // Decoder FSM: waiting for a first pulse, drive high, drive low between pulses
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HIGH = 2'b01,
        ST_LOW  = 2'b10
    } state_t;

    // Direction pin levels
    localparam logic DIR_POS = 1'b0;
    localparam logic DIR_NEG = 1'b1;

    // Finest microstep code; one position unit is 1/2^MS_MAX_DFLT of a full step
    localparam int unsigned MS_MAX_DFLT = 5;

endpackage

// File: rtl/step_pulse_edge.sv
// Input synchroniser stage for the drive interface: two register stages (r0, r1)
// and rise / fall / direction-change decode from them.
module step_pulse_edge
    import step_motor_pkg::*;
#(
    parameter int unsigned C_MICROSTEP_WIDTH = 3
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         i_drive,
    input  logic                         i_dir,
    input  logic [C_MICROSTEP_WIDTH-1:0] i_ms,
    output logic                         o_dir,
    output logic [C_MICROSTEP_WIDTH-1:0] o_ms,
    output logic                         o_rise,
    output logic                         o_fall,
    output logic                         o_dir_change
);

    logic                         r0_drive;
    logic                         r0_dir;
    logic [C_MICROSTEP_WIDTH-1:0] r0_ms;
    logic                         r1_drive;
    logic                         r1_dir;

    // First stage samples the pins; second stage holds the previous sample
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r0_drive <= 1'b0;
            r0_dir   <= DIR_POS;
            r0_ms    <= '0;
            r1_drive <= 1'b0;
            r1_dir   <= DIR_POS;
        end else begin
            r0_drive <= i_drive;
            r0_dir   <= i_dir;
            r0_ms    <= i_ms;
            r1_drive <= r0_drive;
            r1_dir   <= r0_dir;
        end
    end

    assign o_dir        = r0_dir;
    assign o_ms         = r0_ms;
    assign o_rise       = r0_drive & ~r1_drive;
    assign o_fall       = ~r0_drive & r1_drive;
    assign o_dir_change = r0_dir ^ r1_dir;

endmodule

// File: rtl/step_pulse_decoder.sv
// Loop-back monitor for one step_motor channel: rebuilds signed position, pulse
// count and pulse period from drive/dir/ms, and latches drive-timing violations.
module step_pulse_decoder
    import step_motor_pkg::*;
#(
    parameter int unsigned C_STEP_NUMBER_WIDTH = 16,
    parameter int unsigned C_MICROSTEP_WIDTH   = 3,
    parameter int unsigned C_MS_MAX            = MS_MAX_DFLT,
    parameter int unsigned C_POSITION_WIDTH    = 32,
    parameter int unsigned C_PERIOD_WIDTH      = 24,
    parameter int unsigned C_MIN_HIGH          = 2,
    parameter int unsigned C_DIR_SETUP         = 2
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic                                m_drive,
    input  logic                                m_dir,
    input  logic [C_MICROSTEP_WIDTH-1:0]        m_ms,
    input  logic                                clr,
    input  logic                                err_clr,
    output logic signed [C_POSITION_WIDTH-1:0]  pos,
    output logic [C_STEP_NUMBER_WIDTH-1:0]      step_cnt,
    output logic [C_PERIOD_WIDTH-1:0]           period,
    output logic                                period_vld,
    output logic                                moving,
    output logic                                err_width,
    output logic                                err_setup,
    output logic                                err_hold,
    output logic                                err_ms
);

    localparam int unsigned LP_HC_W = $clog2(C_MIN_HIGH + 1) + 1;
    localparam int unsigned LP_DS_W = $clog2(C_DIR_SETUP + 1) + 1;

    localparam logic [C_MICROSTEP_WIDTH-1:0]   LP_MS_MAX    = C_MICROSTEP_WIDTH'(C_MS_MAX);
    localparam logic [C_POSITION_WIDTH-1:0]    LP_POS_ONE   = C_POSITION_WIDTH'(1);
    localparam logic [C_STEP_NUMBER_WIDTH-1:0] LP_STEP_ONE  = C_STEP_NUMBER_WIDTH'(1);
    localparam logic [C_PERIOD_WIDTH-1:0]      LP_PER_ONE   = C_PERIOD_WIDTH'(1);
    localparam logic [C_PERIOD_WIDTH-1:0]      LP_PER_MAX   = '1;
    localparam logic [LP_HC_W-1:0]             LP_HC_ONE    = LP_HC_W'(1);
    localparam logic [LP_HC_W-1:0]             LP_HC_MAX    = '1;
    localparam logic [LP_HC_W:0]               LP_MIN_HIGH  = (LP_HC_W + 1)'(C_MIN_HIGH);
    localparam logic [LP_DS_W-1:0]             LP_DS_ONE    = LP_DS_W'(1);
    localparam logic [LP_DS_W-1:0]             LP_DS_MAX    = '1;
    localparam logic [LP_DS_W-1:0]             LP_DIR_SETUP = LP_DS_W'(C_DIR_SETUP);

    // Decoded input stage
    logic                           w_dir;
    logic [C_MICROSTEP_WIDTH-1:0]   w_ms;
    logic                           w_rise;
    logic                           w_fall;
    logic                           w_dir_change;

    // State and counters
    state_t                         r_state;
    logic [C_POSITION_WIDTH-1:0]    r_pos;
    logic [C_STEP_NUMBER_WIDTH-1:0] r_step_cnt;
    logic [C_PERIOD_WIDTH-1:0]      r_per_cnt;
    logic [C_PERIOD_WIDTH-1:0]      r_period;
    logic                           r_period_vld;
    logic [LP_HC_W-1:0]             r_high_cnt;
    logic [LP_DS_W-1:0]             r_dir_stable;
    logic                           r_err_width;
    logic                           r_err_setup;
    logic                           r_err_hold;
    logic                           r_err_ms;

    // Per-rise arithmetic and violation detection
    logic [C_MICROSTEP_WIDTH-1:0]   w_ms_eff;
    logic [C_POSITION_WIDTH-1:0]    w_inc;
    logic [C_POSITION_WIDTH-1:0]    w_pos_base;
    logic [C_POSITION_WIDTH-1:0]    w_pos_next;
    logic [C_STEP_NUMBER_WIDTH-1:0] w_step_base;
    logic                           w_period_ok;
    logic                           w_high_short;
    logic                           w_setup_short;
    logic                           w_new_width;
    logic                           w_new_setup;
    logic                           w_new_hold;
    logic                           w_new_ms;

    step_pulse_edge #(
        .C_MICROSTEP_WIDTH (C_MICROSTEP_WIDTH)
    ) u_edge (
        .clk          (clk),
        .resetn       (resetn),
        .i_drive      (m_drive),
        .i_dir        (m_dir),
        .i_ms         (m_ms),
        .o_dir        (w_dir),
        .o_ms         (w_ms),
        .o_rise       (w_rise),
        .o_fall       (w_fall),
        .o_dir_change (w_dir_change)
    );

    // Out-of-range microstep codes are clamped to the finest step (inc = 1)
    assign w_ms_eff   = (w_ms > LP_MS_MAX) ? LP_MS_MAX : w_ms;
    assign w_inc      = LP_POS_ONE << (LP_MS_MAX - w_ms_eff);

    // A rise coincident with clr counts from zero
    assign w_pos_base  = clr ? '0 : r_pos;
    assign w_step_base = clr ? '0 : r_step_cnt;
    assign w_pos_next  = (w_dir == DIR_POS) ? (w_pos_base + w_inc) : (w_pos_base - w_inc);

    // Period is only meaningful between two rises of one unbroken pulse train
    assign w_period_ok = !clr && (r_state == ST_LOW) && (r_per_cnt != LP_PER_MAX);

    // r_high_cnt excludes the rise cycle itself, so the drive-high length is count + 1
    assign w_high_short  = ({1'b0, r_high_cnt} + (LP_HC_W + 1)'(1)) < LP_MIN_HIGH;
    // A dir change in the rise cycle itself means zero cycles of setup
    assign w_setup_short = w_dir_change || (r_dir_stable < LP_DIR_SETUP);

    assign w_new_width = w_fall && (r_state == ST_HIGH) && w_high_short;
    assign w_new_setup = w_rise && w_setup_short;
    assign w_new_hold  = w_dir_change && (r_state == ST_HIGH);
    assign w_new_ms    = w_rise && (w_ms > LP_MS_MAX);

    // FSM, position, step count and period counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_pos      <= '0;
            r_step_cnt <= '0;
            r_per_cnt  <= '0;
        end else if (w_rise) begin
            r_state    <= ST_HIGH;
            r_pos      <= w_pos_next;
            r_step_cnt <= w_step_base + LP_STEP_ONE;
            r_per_cnt  <= LP_PER_ONE;
        end else if (clr) begin
            r_state    <= ST_IDLE;
            r_pos      <= '0;
            r_step_cnt <= '0;
            r_per_cnt  <= '0;
        end else begin
            if (r_per_cnt != LP_PER_MAX) begin
                r_per_cnt <= r_per_cnt + LP_PER_ONE;
            end
            case (r_state)
                ST_HIGH: begin
                    if (w_fall) begin
                        r_state <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (r_per_cnt == LP_PER_MAX) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= r_state;
            endcase
        end
    end

    // Period capture and its one-cycle strobe
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_period     <= '0;
            r_period_vld <= 1'b0;
        end else if (w_rise && w_period_ok) begin
            r_period     <= r_per_cnt;
            r_period_vld <= 1'b1;
        end else begin
            r_period_vld <= 1'b0;
        end
    end

    // Drive-high length counter, saturating
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_high_cnt <= '0;
        end else if (w_rise) begin
            r_high_cnt <= '0;
        end else if ((r_state == ST_HIGH) && (r_high_cnt != LP_HC_MAX)) begin
            r_high_cnt <= r_high_cnt + LP_HC_ONE;
        end
    end

    // Cycles since the last dir change, saturating; starts saturated out of reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_dir_stable <= LP_DS_MAX;
        end else if (w_dir_change) begin
            r_dir_stable <= '0;
        end else if (r_dir_stable != LP_DS_MAX) begin
            r_dir_stable <= r_dir_stable + LP_DS_ONE;
        end
    end

    // Sticky error flags; a new violation outranks err_clr in the same cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_err_width <= 1'b0;
            r_err_setup <= 1'b0;
            r_err_hold  <= 1'b0;
            r_err_ms    <= 1'b0;
        end else begin
            r_err_width <= (r_err_width & ~err_clr) | w_new_width;
            r_err_setup <= (r_err_setup & ~err_clr) | w_new_setup;
            r_err_hold  <= (r_err_hold  & ~err_clr) | w_new_hold;
            r_err_ms    <= (r_err_ms    & ~err_clr) | w_new_ms;
        end
    end

    assign pos        = r_pos;
    assign step_cnt   = r_step_cnt;
    assign period     = r_period;
    assign period_vld = r_period_vld;
    assign moving     = (r_state != ST_IDLE);
    assign err_width  = r_err_width;
    assign err_setup  = r_err_setup;
    assign err_hold   = r_err_hold;
    assign err_ms     = r_err_ms;

endmodule
